uart_rx_sipo: RTL and testbench

//  Receiver-side deframer for the UART link: oversamples the serial line, detects the

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_sipo.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_sipo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings, receiver
// FSM states and default framing parameters.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      PAR_NONE0 = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_EVEN  = 2'b10,
      PAR_NONE3 = 2'b11
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   // True when the frame carries a parity bit.
   function automatic logic parity_en(input parity_e p);
      return (p == PAR_ODD) || (p == PAR_EVEN);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Ports: clk, reset (sync, active-high), din (async line), dout (synchronised line).
// Both flops reset to 1 so the line reads idle coming out of reset.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         dout <= 1'b1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive deframer: oversampled start-bit detection, LSB-first data shift,
// optional parity check and stop-bit check, parallel byte out with a 1-cycle strobe.
// Ports: baud_clk (oversampled clock), reset (sync, active-high), data_rx (serial line),
//        parity_type (00/11 none, 01 odd, 10 even), data_parll (last byte),
//        data_valid (1-cycle strobe), active_flag / done_flag (frame in progress / idle),
//        parity_error / stop_error (flags of the last delivered frame).
module uart_rx_sipo
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  baud_clk,
   input  logic                  reset,
   input  logic                  data_rx,
   input  logic [1:0]            parity_type,
   output logic [DATA_WIDTH-1:0] data_parll,
   output logic                  data_valid,
   output logic                  active_flag,
   output logic                  done_flag,
   output logic                  parity_error,
   output logic                  stop_error
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

   logic                  line;
   rx_state_e             state, state_nxt;
   logic [TICK_W-1:0]     tick_cnt, tick_nxt;
   logic [BIT_W-1:0]      bit_cnt, bit_nxt;
   logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
   logic                  par_acc, par_acc_nxt;
   logic                  par_err, par_err_nxt;
   parity_e               ptype, ptype_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  valid_nxt, active_nxt, done_nxt, perr_nxt, serr_nxt;
   logic                  mid_tick_c, full_tick_c;

   uart_rx_sync u_sync (
      .clk   (baud_clk),
      .reset (reset),
      .din   (data_rx),
      .dout  (line)
   );

   // Start bit is confirmed at its mid-point; later bits are sampled one bit period apart.
   assign mid_tick_c  = (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
   assign full_tick_c = (tick_cnt == TICK_W'(OVERSAMPLE - 1));

   // State and all datapath/output registers.
   always_ff @(posedge baud_clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         par_acc      <= 1'b0;
         par_err      <= 1'b0;
         ptype        <= PAR_NONE0;
         data_parll   <= '0;
         data_valid   <= 1'b0;
         active_flag  <= 1'b0;
         done_flag    <= 1'b1;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         state        <= state_nxt;
         tick_cnt     <= tick_nxt;
         bit_cnt      <= bit_nxt;
         shift_reg    <= shift_nxt;
         par_acc      <= par_acc_nxt;
         par_err      <= par_err_nxt;
         ptype        <= ptype_nxt;
         data_parll   <= data_nxt;
         data_valid   <= valid_nxt;
         active_flag  <= active_nxt;
         done_flag    <= done_nxt;
         parity_error <= perr_nxt;
         stop_error   <= serr_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state;
      tick_nxt    = tick_cnt;
      bit_nxt     = bit_cnt;
      shift_nxt   = shift_reg;
      par_acc_nxt = par_acc;
      par_err_nxt = par_err;
      ptype_nxt   = ptype;
      data_nxt    = data_parll;
      valid_nxt   = 1'b0;
      active_nxt  = active_flag;
      done_nxt    = done_flag;
      perr_nxt    = parity_error;
      serr_nxt    = stop_error;

      unique case (state)
         ST_IDLE: begin
            if (!line) begin
               state_nxt = ST_START;
               tick_nxt  = '0;
            end
         end
         ST_START: begin
            if (mid_tick_c) begin
               tick_nxt = '0;
               if (!line) begin
                  state_nxt   = ST_DATA;
                  active_nxt  = 1'b1;
                  done_nxt    = 1'b0;
                  ptype_nxt   = parity_e'(parity_type);
                  bit_nxt     = '0;
                  par_acc_nxt = 1'b0;
                  par_err_nxt = 1'b0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               tick_nxt = tick_cnt + TICK_W'(1);
            end
         end
         ST_DATA: begin
            if (full_tick_c) begin
               tick_nxt    = '0;
               shift_nxt   = (shift_reg >> 1) | (DATA_WIDTH'(line) << (DATA_WIDTH - 1));
               par_acc_nxt = par_acc ^ line;
               if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                  bit_nxt   = '0;
                  state_nxt = parity_en(ptype) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_nxt = bit_cnt + BIT_W'(1);
               end
            end else begin
               tick_nxt = tick_cnt + TICK_W'(1);
            end
         end
         ST_PARITY: begin
            if (full_tick_c) begin
               tick_nxt    = '0;
               // Odd parity expects an overall XOR of 1, even parity expects 0.
               par_err_nxt = (ptype == PAR_ODD) ? ~(par_acc ^ line) : (par_acc ^ line);
               state_nxt   = ST_STOP;
            end else begin
               tick_nxt = tick_cnt + TICK_W'(1);
            end
         end
         ST_STOP: begin
            if (full_tick_c) begin
               // Leave at stop mid-bit so a start bit with no idle gap is still caught.
               tick_nxt   = '0;
               data_nxt   = shift_reg;
               perr_nxt   = par_err;
               serr_nxt   = ~line;
               valid_nxt  = 1'b1;
               active_nxt = 1'b0;
               done_nxt   = 1'b1;
               state_nxt  = ST_IDLE;
            end else begin
               tick_nxt = tick_cnt + TICK_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: table of frames plus hand-written corner cases,
// with a scoreboard queue of expected deliveries checked by a monitor on every strobe.
module tb_uart_rx_sipo;

   localparam int unsigned OS = 16;

   logic       baud_clk = 1'b0;
   logic       reset;
   logic       data_rx;
   logic [1:0] parity_type;
   logic [7:0] data_parll;
   logic       data_valid, active_flag, done_flag, parity_error, stop_error;

   uart_rx_sipo #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
      .baud_clk     (baud_clk),
      .reset        (reset),
      .data_rx      (data_rx),
      .parity_type  (parity_type),
      .data_parll   (data_parll),
      .data_valid   (data_valid),
      .active_flag  (active_flag),
      .done_flag    (done_flag),
      .parity_error (parity_error),
      .stop_error   (stop_error)
   );

   always #5 baud_clk = ~baud_clk;

   typedef struct {
      logic [7:0] data;
      logic [1:0] ptype;
      logic       par_bit;
      logic       stop_bit;
      logic       flip;
      logic       exp_perr;
      logic       exp_serr;
   } vec_t;

   typedef struct {
      logic [7:0]  data;
      logic        perr;
      logic        serr;
      int unsigned cyc;
   } exp_t;

   vec_t        vecs[$];
   exp_t        sb[$];
   exp_t        e;
   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;
   int unsigned last_vcyc = 0;
   int unsigned prev_vcyc = 0;
   logic        prev_valid = 1'b0;

   always @(posedge baud_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected frame.
   always @(negedge baud_clk) begin
      if (data_valid === 1'b1) begin
         chk("valid_back_to_back", 32'(prev_valid), 32'd0);
         prev_vcyc = last_vcyc;
         last_vcyc = cyc;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got pulse with data 0x%0h expected no pulse", data_parll);
         end else begin
            e = sb.pop_front();
            chk("data_parll", 32'(data_parll), 32'(e.data));
            chk("parity_error", 32'(parity_error), 32'(e.perr));
            chk("stop_error", 32'(stop_error), 32'(e.serr));
            chk("valid_cycle", cyc, e.cyc);
         end
      end
      prev_valid = (data_valid === 1'b1);
   end

   task automatic drive_bit(input logic b);
      data_rx = b;
      repeat (OS) @(negedge baud_clk);
   endtask

   // Drives one frame starting at a negedge; the strobe is expected 1 sampling edge
   // + 2 sync cycles + 1.5 bit periods + data/parity bit periods later.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                             input logic sbit, input logic flip,
                             input logic eperr, input logic eserr);
      logic has_par;
      exp_t x;
      has_par = (pt == 2'b01) || (pt == 2'b10);
      parity_type = pt;
      x.data = d;
      x.perr = eperr;
      x.serr = eserr;
      x.cyc  = cyc + 1 + 2 + (OS * 3) / 2 + 8 * OS + (has_par ? OS : 0);
      sb.push_back(x);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (flip && i == 4) parity_type = 2'b00;
         drive_bit(d[i]);
      end
      if (has_par) drive_bit(pb);
      drive_bit(sbit);
      data_rx = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge baud_clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_active, seen_busy;

      vecs.push_back('{8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h3C, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h3C, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{8'h01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h01, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{8'hFF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h80, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});

      // Reset held 3 cycles with the line low.
      reset = 1'b1;
      data_rx = 1'b0;
      parity_type = 2'b00;
      @(negedge baud_clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_done_flag", 32'(done_flag), 32'd1);
         chk("reset_active_flag", 32'(active_flag), 32'd0);
         chk("reset_data_valid", 32'(data_valid), 32'd0);
         @(negedge baud_clk);
      end
      chk("reset_data_parll", 32'(data_parll), 32'd0);
      chk("reset_errors", 32'({parity_error, stop_error}), 32'd0);
      data_rx = 1'b1;
      @(negedge baud_clk);
      reset = 1'b0;
      repeat (4) @(negedge baud_clk);

      // Start-bit glitch: 4 cycles low must be rejected.
      data_rx = 1'b0;
      repeat (4) @(negedge baud_clk);
      data_rx = 1'b1;
      seen_active = 1'b0;
      seen_busy = 1'b0;
      repeat (40) begin
         @(negedge baud_clk);
         seen_active |= active_flag;
         seen_busy |= ~done_flag;
      end
      chk("glitch_active_flag", 32'(seen_active), 32'd0);
      chk("glitch_done_flag", 32'(seen_busy), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         send_frame(vecs[i].data, vecs[i].ptype, vecs[i].par_bit, vecs[i].stop_bit,
                    vecs[i].flip, vecs[i].exp_perr, vecs[i].exp_serr);
         drive_bit(1'b1);
         drive_bit(1'b1);
      end
      drain();

      // Framing error, flags held through idle, then cleared by a clean frame.
      send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) drive_bit(1'b1);
      chk("hold_stop_error", 32'(stop_error), 32'd1);
      chk("hold_data_parll", 32'(data_parll), 32'h55);
      chk("idle_done_flag", 32'(done_flag), 32'd1);
      send_frame(8'h0F, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b1);
      drain();

      // Back-to-back frames with no idle gap.
      send_frame(8'h12, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'h34, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b1);
      drain();
      chk("b2b_spacing", last_vcyc - prev_vcyc, 32'(10 * OS));

      // Reset during data bit 4: frame dropped, outputs return to reset values.
      parity_type = 2'b00;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0]);
      data_rx = 1'b0;
      repeat (OS / 2) @(negedge baud_clk);
      chk("midframe_active_flag", 32'(active_flag), 32'd1);
      chk("midframe_done_flag", 32'(done_flag), 32'd0);
      reset = 1'b1;
      @(negedge baud_clk);
      reset = 1'b0;
      data_rx = 1'b1;
      chk("midreset_active_flag", 32'(active_flag), 32'd0);
      chk("midreset_done_flag", 32'(done_flag), 32'd1);
      chk("midreset_data_parll", 32'(data_parll), 32'd0);
      chk("midreset_errors", 32'({parity_error, stop_error, data_valid}), 32'd0);
      repeat (12) drive_bit(1'b1);
      chk("midreset_quiet_active", 32'(active_flag), 32'd0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
